// File: rtl/game_end_ctrl.sv
// End-of-game banner sequencer: latches the result, slides the banner in per frame,
// holds it until a fresh R press, then pulses restart_req for one cycle.
module game_end_ctrl #(
  parameter int SLIDE_START = 64,
  parameter int SLIDE_STEP  = 1,
  parameter int HOLD_MIN    = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       win_valid,
  input  logic       win_color,
  input  logic       board_full,
  input  logic       r_pressed,
  output logic       is_ending_exist,
  output logic       white_win,
  output logic       black_win,
  output logic       tie,
  output logic [6:0] slide_offset,
  output logic       input_lock,
  output logic       restart_req
);

  typedef enum logic [1:0] {PLAY, SLIDE, HOLD, CLEAR} state_t;

  localparam logic [6:0] START_OFF = 7'(SLIDE_START);
  localparam logic [7:0] STEP8     = 8'(SLIDE_STEP);
  localparam logic [7:0] HOLD8     = 8'(HOLD_MIN);

  state_t     state_q;
  logic [7:0] hold_cnt_q;
  logic       r_prev_q;
  logic [7:0] off_diff;
  logic [6:0] slide_d;
  logic       r_rise;

  // Eight-bit subtraction: bit 7 set means the step overshot zero.
  assign off_diff = {1'b0, slide_offset} - STEP8;
  assign slide_d  = off_diff[7] ? 7'd0 : off_diff[6:0];
  assign r_rise   = r_pressed && !r_prev_q;

  // Edge history keeps sampling through Reset so a held key never looks like a new press.
  always_ff @(posedge Clk) begin
    r_prev_q <= r_pressed;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= PLAY;
      hold_cnt_q      <= 8'd0;
      is_ending_exist <= 1'b0;
      white_win       <= 1'b0;
      black_win       <= 1'b0;
      tie             <= 1'b0;
      input_lock      <= 1'b0;
      restart_req     <= 1'b0;
      slide_offset    <= START_OFF;
    end else begin
      case (state_q)
        PLAY: begin
          if (win_valid || board_full) begin
            white_win       <= win_valid && !win_color;
            black_win       <= win_valid && win_color;
            tie             <= !win_valid;
            is_ending_exist <= 1'b1;
            input_lock      <= 1'b1;
            slide_offset    <= START_OFF;
            state_q         <= SLIDE;
          end
        end
        SLIDE: begin
          if (frame_tick) begin
            slide_offset <= slide_d;
            if (slide_d == 7'd0) begin
              state_q    <= HOLD;
              hold_cnt_q <= 8'd0;
            end
          end
        end
        HOLD: begin
          slide_offset <= 7'd0;
          if (r_rise && hold_cnt_q == HOLD8) begin
            state_q         <= CLEAR;
            restart_req     <= 1'b1;
            white_win       <= 1'b0;
            black_win       <= 1'b0;
            tie             <= 1'b0;
            is_ending_exist <= 1'b0;
            input_lock      <= 1'b0;
            slide_offset    <= START_OFF;
          end else if (frame_tick && hold_cnt_q < HOLD8) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        CLEAR: begin
          restart_req <= 1'b0;
          state_q     <= PLAY;
        end
        default: state_q <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_game_end_ctrl.sv
// Directed bench for game_end_ctrl: default instance plus a SLIDE_STEP=3 / HOLD_MIN=2 instance.
module tb_game_end_ctrl;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_tick = 1'b0, win_valid = 1'b0, win_color = 1'b0, board_full = 1'b0, r_pressed = 1'b0;
  logic is_ending_exist, white_win, black_win, tie, input_lock, restart_req;
  logic [6:0] slide_offset;
  logic e3, w3, b3, t3, l3, rq3;
  logic [6:0] off3;
  int total = 0;
  int bad = 0;
  int rcount = 0;

  always #10 Clk = ~Clk;

  game_end_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .win_valid(win_valid),
    .win_color(win_color), .board_full(board_full), .r_pressed(r_pressed),
    .is_ending_exist(is_ending_exist), .white_win(white_win), .black_win(black_win),
    .tie(tie), .slide_offset(slide_offset), .input_lock(input_lock), .restart_req(restart_req)
  );

  game_end_ctrl #(.SLIDE_START(64), .SLIDE_STEP(3), .HOLD_MIN(2)) dut3 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .win_valid(win_valid),
    .win_color(win_color), .board_full(board_full), .r_pressed(r_pressed),
    .is_ending_exist(e3), .white_win(w3), .black_win(b3),
    .tie(t3), .slide_offset(off3), .input_lock(l3), .restart_req(rq3)
  );

  always @(negedge Clk) if (restart_req === 1'b1) rcount++;

  // status = {is_ending_exist, white_win, black_win, tie, input_lock, restart_req}
  function automatic logic [5:0] status();
    return {is_ending_exist, white_win, black_win, tie, input_lock, restart_req};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; frame_tick = 0; win_valid = 0; win_color = 0; board_full = 0; r_pressed = 0;
    step(); step();
    Reset = 1'b0;
  endtask

  task automatic do_win(input logic color);
    win_valid = 1'b1; win_color = color; step();
    win_valid = 1'b0; win_color = 1'b0;
  endtask

  task automatic press_r();
    r_pressed = 1'b1; step();
    r_pressed = 1'b0; step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (status() !== 6'b000000) begin bad++; $display("FAIL reset_status got=%b want=000000", status()); end
    total++; if (slide_offset !== 7'd64) begin bad++; $display("FAIL reset_offset got=%0d want=64", slide_offset); end
    total++; if (off3 !== 7'd64) begin bad++; $display("FAIL reset_offset3 got=%0d want=64", off3); end
  endtask

  task automatic test_white_win();
    do_reset();
    do_win(1'b0);
    total++; if (status() !== 6'b110010) begin bad++; $display("FAIL white_status got=%b want=110010", status()); end
    total++; if (slide_offset !== 7'd64) begin bad++; $display("FAIL white_offset0 got=%0d want=64", slide_offset); end
    tick(1);
    total++; if (slide_offset !== 7'd63) begin bad++; $display("FAIL white_offset1 got=%0d want=63", slide_offset); end
    tick(62);
    total++; if (slide_offset !== 7'd1) begin bad++; $display("FAIL white_offset63 got=%0d want=1", slide_offset); end
    tick(1);
    total++; if (slide_offset !== 7'd0) begin bad++; $display("FAIL white_offset64 got=%0d want=0", slide_offset); end
    tick(5);
    total++; if (slide_offset !== 7'd0) begin bad++; $display("FAIL white_hold_offset got=%0d want=0", slide_offset); end
  endtask

  task automatic test_precedence_and_tie();
    do_reset();
    win_valid = 1'b1; win_color = 1'b1; board_full = 1'b1; step();
    win_valid = 1'b0; win_color = 1'b0; board_full = 1'b0;
    total++; if (status() !== 6'b101010) begin bad++; $display("FAIL prec_status got=%b want=101010", status()); end
    board_full = 1'b1; tick(2); board_full = 1'b0; tick(1); board_full = 1'b1; step();
    win_valid = 1'b1; win_color = 1'b0; step(); win_valid = 1'b0; board_full = 1'b0;
    total++; if (status() !== 6'b101010) begin bad++; $display("FAIL prec_locked got=%b want=101010", status()); end
    total++; if (slide_offset !== 7'd61) begin bad++; $display("FAIL prec_offset got=%0d want=61", slide_offset); end
    do_reset();
    board_full = 1'b1; step(); board_full = 1'b0;
    total++; if (status() !== 6'b100110) begin bad++; $display("FAIL tie_status got=%b want=100110", status()); end
  endtask

  task automatic test_r_held();
    int r0;
    do_reset();
    do_win(1'b1);
    r_pressed = 1'b1;
    tick(10);
    r0 = rcount;
    tick(54 + 40);
    total++; if (rcount !== r0) begin bad++; $display("FAIL rheld_no_restart got=%0d want=%0d", rcount, r0); end
    total++; if (status() !== 6'b101010) begin bad++; $display("FAIL rheld_status got=%b want=101010", status()); end
    r_pressed = 1'b0; step();
    r_pressed = 1'b1; step();
    total++; if (status() !== 6'b000001) begin bad++; $display("FAIL restart_status got=%b want=000001", status()); end
    total++; if (slide_offset !== 7'd64) begin bad++; $display("FAIL restart_offset got=%0d want=64", slide_offset); end
    step();
    total++; if (status() !== 6'b000000) begin bad++; $display("FAIL restart_one_cycle got=%b want=000000", status()); end
    total++; if (rcount !== r0 + 1) begin bad++; $display("FAIL restart_count got=%0d want=%0d", rcount, r0 + 1); end
    r_pressed = 1'b0; step();
  endtask

  task automatic test_r_early();
    int r0;
    do_reset();
    do_win(1'b0);
    tick(64);
    r0 = rcount;
    tick(10);
    press_r();
    total++; if (status() !== 6'b110010) begin bad++; $display("FAIL early10_status got=%b want=110010", status()); end
    tick(19);
    press_r();
    total++; if (rcount !== r0) begin bad++; $display("FAIL early29_no_restart got=%0d want=%0d", rcount, r0); end
    tick(1);
    step(); step();
    total++; if (rcount !== r0) begin bad++; $display("FAIL early_no_queue got=%0d want=%0d", rcount, r0); end
    r_pressed = 1'b1; step();
    total++; if (restart_req !== 1'b1) begin bad++; $display("FAIL at30_restart got=%b want=1", restart_req); end
    r_pressed = 1'b0; step();
  endtask

  task automatic test_mid_reset();
    do_reset();
    do_win(1'b0);
    tick(44);
    total++; if (slide_offset !== 7'd20) begin bad++; $display("FAIL mid_pre_offset got=%0d want=20", slide_offset); end
    Reset = 1'b1; step(); Reset = 1'b0;
    total++; if (status() !== 6'b000000) begin bad++; $display("FAIL mid_status got=%b want=000000", status()); end
    total++; if (slide_offset !== 7'd64) begin bad++; $display("FAIL mid_offset got=%0d want=64", slide_offset); end
    do_win(1'b1);
    total++; if (status() !== 6'b101010) begin bad++; $display("FAIL mid_rewin got=%b want=101010", status()); end
    tick(1);
    total++; if (slide_offset !== 7'd63) begin bad++; $display("FAIL mid_reslide got=%0d want=63", slide_offset); end
  endtask

  task automatic test_step3();
    int exp;
    do_reset();
    do_win(1'b0);
    for (int k = 1; k <= 22; k++) begin
      tick(1);
      exp = 64 - 3 * k;
      if (exp < 0) exp = 0;
      total++; if (off3 !== 7'(exp)) begin bad++; $display("FAIL step3_k%0d got=%0d want=%0d", k, off3, exp); end
    end
    tick(2);
    r_pressed = 1'b1; step();
    total++; if (rq3 !== 1'b1 || e3 !== 1'b0 || off3 !== 7'd64) begin
      bad++; $display("FAIL step3_restart got=req%b/end%b/off%0d want=req1/end0/off64", rq3, e3, off3);
    end
    r_pressed = 1'b0; step();
  endtask

  task automatic test_tick_coincident();
    do_reset();
    win_valid = 1'b1; frame_tick = 1'b1; step();
    win_valid = 1'b0; frame_tick = 1'b0;
    total++; if (slide_offset !== 7'd64) begin bad++; $display("FAIL coinc_offset got=%0d want=64", slide_offset); end
    repeat (100) step();
    total++; if (slide_offset !== 7'd64) begin bad++; $display("FAIL idle_offset got=%0d want=64", slide_offset); end
    tick(1);
    total++; if (slide_offset !== 7'd63) begin bad++; $display("FAIL coinc_first_dec got=%0d want=63", slide_offset); end
  endtask

  initial begin
    test_reset();
    test_white_win();
    test_precedence_and_tie();
    test_r_held();
    test_r_early();
    test_mid_reset();
    test_step3();
    test_tick_coincident();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/game_end_ctrl.md
Name: game_end_ctrl

Overview:
- Sequences the end-of-game banner animation.
- Detects end-of-game from the rules logic and latches a one-hot result (white win, black win or tie).
- Drives the banner's vertical slide-in offset per frame, locks board input while the banner is up, and issues a one-cycle restart request when the player presses R.
- Sits between the game-rules logic and the ending-banner sprite drawer; it replaces the drawer's free-running offset counter.

Parameters:
- SLIDE_START, 64, initial banner Y offset in pixels (1..127).
- SLIDE_STEP, 1, pixels removed per frame tick (1..SLIDE_START).
- HOLD_MIN, 30, frame ticks in HOLD before R is honoured (0..255).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-Clk-cycle pulse per video frame (~60 Hz), synchronous to Clk.
- win_valid  in  1  rules logic reports five-in-a-row this cycle.
- win_color  in  1  winner colour when win_valid: 0 = white, 1 = black.
- board_full  in  1  no empty squares remain.
- r_pressed  in  1  R key level, already synchronous to Clk.
- is_ending_exist  out  1  banner visible.
- white_win  out  1  result flag.
- black_win  out  1  result flag.
- tie  out  1  result flag.
- slide_offset  out  7  banner Y offset added to the banner base Y.
- input_lock  out  1  board moves blocked.
- restart_req  out  1  one-cycle pulse that requests a board and game reset.

Behaviour:
- Clock and reset: single clock Clk; Reset is synchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values: state PLAY; is_ending_exist, white_win, black_win, tie, input_lock and restart_req = 0; slide_offset = SLIDE_START; hold_cnt = 0.
- Reset mid-operation: Reset in any state gives the reset values at the next edge.
- FSM states: PLAY, SLIDE, HOLD, CLEAR.
- PLAY:
  - Sample win_valid and board_full every cycle.
  - win_valid=1: latch white_win = ~win_color, black_win = win_color, tie = 0. Win takes precedence when win_valid and board_full are both 1.
  - Else board_full=1: latch tie = 1.
  - On either event: is_ending_exist = 1, input_lock = 1 and slide_offset = SLIDE_START from the next cycle; go to SLIDE. Latency is one Clk cycle.
  - r_pressed is ignored in PLAY.
- SLIDE:
  - Each frame_tick: slide_offset = max(slide_offset - SLIDE_STEP, 0). Compute the subtraction 8 bits wide so it cannot wrap.
  - The update that produces 0 also moves the FSM to HOLD with hold_cnt = 0.
  - No frame_tick: offset holds.
  - A tick coincident with the PLAY->SLIDE transition cycle is not counted.
- HOLD:
  - slide_offset stays 0.
  - Each frame_tick increments hold_cnt (8 bits), saturating at HOLD_MIN.
  - A rising edge of r_pressed (r_pressed=1, previous-cycle r_pressed=0) when hold_cnt == HOLD_MIN moves the FSM to CLEAR.
  - Edges with hold_cnt < HOLD_MIN are discarded and do not queue.
  - R held continuously from SLIDE into HOLD produces no edge; it must be released and pressed again.
- r_pressed edge register: updates every cycle in all states, including during Reset (reset value 0).
- CLEAR: lasts exactly one cycle.
  - restart_req = 1 for exactly that cycle.
  - Result flags, is_ending_exist and input_lock cleared to 0 together with the restart_req assertion.
  - slide_offset = SLIDE_START; next state PLAY.
- Ignored inputs: win_valid and board_full are ignored in SLIDE, HOLD and CLEAR. The result never changes once latched.
- Invariants:
  - Exactly one of white_win/black_win/tie is 1 whenever is_ending_exist = 1; all three are 0 otherwise.
  - input_lock == is_ending_exist.

Test Plan:
- Reset, then win_valid=1, win_color=0 for one cycle -> next cycle: is_ending_exist=1, white_win=1, input_lock=1, slide_offset=64. After 64 frame_ticks: slide_offset=0 and state HOLD.
- win_valid=1, win_color=1, board_full=1 in the same cycle -> black_win=1, tie=0, white_win=0. Then board_full=0 → 1 toggling during SLIDE -> no change. Separately, board_full=1 alone from PLAY -> tie=1.
- R behaviour:
  - R held from SLIDE into HOLD, 40 ticks pass -> no restart.
  - Release, then press -> restart_req=1 for exactly one cycle; all flags, is_ending_exist and input_lock are 0 with that assertion; slide_offset=64.
  - R pressed at hold_cnt=10 (HOLD_MIN=30) -> ignored.
- Reset asserted mid-SLIDE at slide_offset=20 -> next cycle: all flags 0, slide_offset=64, state PLAY. A subsequent win_valid is accepted normally.
- SLIDE_START=64, SLIDE_STEP=3 -> offsets 61, 58, …, 4, 1, 0 (22 ticks, saturating with no wrap); the HOLD transition coincides with offset 0.
- frame_tick coincident with the win_valid cycle -> first decrement only on the next tick in SLIDE; frame_tick absent for 100 cycles -> slide_offset constant.
